// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the execute stage.
//                Multiplies by shift-add over the operand magnitudes
//                (MUL_STEPS multiplier bits per cycle) and divides by
//                restoring division (one quotient bit per cycle). It then
//                applies a final two's-complement sign fix. Divide-by-zero
//                and signed overflow finish in one cycle.
//  Ports       : clock     - rising-edge clock
//                reset     - asynchronous, active-low
//                start     - request an operation (sampled in IDLE only)
//                op        - RV32M funct3 (MUL..REMU)
//                rs1/rs2   - operands (dividend/multiplicand, divisor/multiplier)
//                flush     - abort current operation
//                stall_req - hold D/X while an operation is being computed
//                busy      - unit is not IDLE
//                done      - one-cycle pulse, result valid
//                result    - registered result, held until next completion
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int MUL_STEPS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW           = $clog2(XLEN + 1);
  localparam logic [CW-1:0] C_MUL_CYCLES = CW'(XLEN / MUL_STEPS);
  localparam logic [CW-1:0] C_DIV_CYCLES = CW'(XLEN);
  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [XLEN-1:0] C_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  generate
    if ((XLEN % 2) != 0 || XLEN < 8 ||
        !(MUL_STEPS == 1 || MUL_STEPS == 2 || MUL_STEPS == 4) ||
        (XLEN % MUL_STEPS) != 0) begin : g_bad_params
      $error("muldiv_unit: illegal XLEN/MUL_STEPS combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // negate the final result
  logic [XLEN-1:0]   mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic [XLEN-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0]   low_q, low_d;     // multiplier->product low / dividend->quotient
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode in IDLE
  logic              in_s1, in_s2, in_neg;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, sovf;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 for MUL, MULH, DIV, REM
    in_s1  = rs1[XLEN-1] & (op != 3'd3) & (op != 3'd5) & (op != 3'd7);
    in_s2  = rs2[XLEN-1] & ((op == 3'd0) | (op == 3'd1) | (op == 3'd4) | (op == 3'd6));
    // The remainder follows the dividend sign; everything else the sign product
    in_neg = (op == 3'd6) ? in_s1 : (in_s1 ^ in_s2);
    abs1   = in_s1 ? -rs1 : rs1;
    abs2   = in_s2 ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    sovf     = ((op == 3'd4) | (op == 3'd6)) & (rs1 == C_MIN) & (rs2 == '1);
    if (div_zero) fast_res = op[1] ? rs1 : '1;
    else          fast_res = op[1] ? '0  : rs1;
  end

  // Shift-add multiply: MUL_STEPS iterations of the product register per cycle
  logic [XLEN-1:0]   mul_acc, mul_low;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_acc = acc_q;
    mul_low = low_q;
    mul_sum = '0;
    for (int i = 0; i < MUL_STEPS; i++) begin
      mul_sum = {1'b0, mul_acc} + (mul_low[0] ? {1'b0, mcand_q} : '0);
      mul_low = {mul_sum[0], mul_low[XLEN-1:1]};
      mul_acc = mul_sum[XLEN:1];
    end
    prod_raw = {mul_acc, mul_low};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    mul_res  = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  // Restoring divide: one quotient bit per cycle
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_acc, div_low, quo_fix, rem_fix, div_res;

  always_comb begin
    div_sh  = {acc_q, low_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, mcand_q});
    // When div_ge holds the true difference is below 2**XLEN, so the low bits suffice
    div_acc = div_ge ? (div_sh[XLEN-1:0] - mcand_q) : div_sh[XLEN-1:0];
    div_low = {low_q[XLEN-2:0], div_ge};
    quo_fix = neg_q ? -div_low : div_low;
    rem_fix = neg_q ? -div_acc : div_acc;
    div_res = op_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    low_d    = low_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          neg_d = in_neg;
          acc_d = '0;
          if (op[2]) begin
            mcand_d = abs2;
            low_d   = abs1;
            cnt_d   = C_DIV_CYCLES;
            if (div_zero || sovf) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_DIV;
            end
          end else begin
            mcand_d = abs1;
            low_d   = abs2;
            cnt_d   = C_MUL_CYCLES;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_acc;
          low_d = mul_low;
          cnt_d = cnt_q - C_ONE;
          if (cnt_q == C_ONE) begin
            result_d = mul_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_acc;
          low_d = div_low;
          cnt_d = cnt_q - C_ONE;
          if (cnt_q == C_ONE) begin
            result_d = div_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign stall_req = ((state_q == S_IDLE) && start && !flush) ||
                     (state_q == S_MUL) || (state_q == S_DIV);
  assign busy      = (state_q != S_IDLE);
  // A flush in the DONE cycle withdraws the completion
  assign done      = (state_q == S_DONE) && !flush;
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. Two instances share
//                the stimulus (MUL_STEPS=1 and MUL_STEPS=4, XLEN=32). A
//                vector table, a randomized run against a 64-bit arithmetic
//                reference and hand-written flush/reset/busy-start sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_i  = 3'd0;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic        flush = 1'b0;

  logic        stall_a, busy_a, done_a;
  logic [31:0] result_a;
  logic        stall_b, busy_b, done_b;
  logic [31:0] result_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_exp = 32'd0;

  muldiv_unit #(.XLEN(32), .MUL_STEPS(1)) u_a (
    .clock(clock), .reset(reset), .start(start), .op(op_i), .rs1(rs1_i), .rs2(rs2_i),
    .flush(flush), .stall_req(stall_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  muldiv_unit #(.XLEN(32), .MUL_STEPS(4)) u_b (
    .clock(clock), .reset(reset), .start(start), .op(op_i), .rs1(rs1_i), .rs2(rs2_i),
    .flush(flush), .stall_req(stall_b), .busy(busy_b), .done(done_b), .result(result_b)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Architectural RV32M semantics using plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Issues one operation and watches both instances for 36 cycles.
  // poke_cyc > 0 raises start with different operands in that busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input int poke_cyc);
    int lat_a, lat_b, nd_a, nd_b, ns_a, ns_b, exp_la, exp_lb, exp_sa;
    bit fast;
    fast   = (o >= 3'd4) && ((b == 32'd0) ||
             ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_la = fast ? 1 : 33;
    exp_lb = fast ? 1 : ((o < 3'd4) ? 9 : 33);
    exp_sa = exp_la;
    lat_a = 0; lat_b = 0; nd_a = 0; nd_b = 0;
    op_i = o; rs1_i = a; rs2_i = b; start = 1'b1;
    #1;
    ns_a = stall_a ? 1 : 0;
    ns_b = stall_b ? 1 : 0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (done_a) begin nd_a++; if (lat_a == 0) lat_a = c; end
      if (done_b) begin nd_b++; if (lat_b == 0) lat_b = c; end
      if (stall_a) ns_a++;
      if (stall_b) ns_b++;
      if (c == poke_cyc) begin
        start = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s result_a", name), result_a, exp);
    chk($sformatf("%s result_b", name), result_b, exp);
    chk($sformatf("%s latency_a", name), lat_a, exp_la);
    chk($sformatf("%s latency_b", name), lat_b, exp_lb);
    chk($sformatf("%s done_pulses_a", name), nd_a, 1);
    chk($sformatf("%s done_pulses_b", name), nd_b, 1);
    chk($sformatf("%s stall_cycles_a", name), ns_a, exp_sa);
    if (o < 3'd4 && !fast) chk($sformatf("%s stall_cycles_b", name), ns_b, 9);
    last_exp = exp;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int nd;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 32'h242D_2080};
    vecs[13] = '{3'd1, 32'h8000_0000,  32'h7FFF_FFFF, 32'hC000_0000};
    vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[15] = '{3'd7, 32'd5,          32'd0,         32'd5};
    vecs[16] = '{3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF};

    // Reset state
    tick(); tick();
    chk("reset result_a", result_a, 32'd0);
    chk("reset result_b", result_b, 32'd0);
    chk("reset busy_a", {31'd0, busy_a}, 32'd0);
    chk("reset done_a", {31'd0, done_a}, 32'd0);
    chk("reset stall_a", {31'd0, stall_a}, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 17; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = ra >> $urandom_range(0, 31); rb = rb >> $urandom_range(0, 31); end
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro), 0);
    end

    // flush together with start in IDLE: start is ignored
    start = 1'b1; flush = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3;
    #1;
    chk("flush+start stall_a", {31'd0, stall_a}, 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy_a", {31'd0, busy_a}, 32'd0);
    chk("flush+start busy_b", {31'd0, busy_b}, 32'd0);

    // Flush mid-divide: back to IDLE, no done, result unchanged
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "pre-flush", 0);
    op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy_a", {31'd0, busy_a}, 32'd0);
    chk("flush busy_b", {31'd0, busy_b}, 32'd0);
    chk("flush stall_a", {31'd0, stall_a}, 32'd0);
    nd = 0;
    for (int c = 0; c < 36; c++) begin
      if (done_a || done_b) nd++;
      tick();
    end
    chk("flush no_done", nd, 0);
    chk("flush result_a held", result_a, last_exp);
    chk("flush result_b held", result_b, last_exp);
    run_op(3'd4, 32'd1000, 32'd3, 32'd333, "post-flush", 0);

    // Asynchronous reset mid-divide
    op_i = 3'd6; rs1_i = 32'd1000; rs2_i = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b0;
    #1;
    chk("async reset result_a", result_a, 32'd0);
    chk("async reset result_b", result_b, 32'd0);
    chk("async reset busy_a", {31'd0, busy_a}, 32'd0);
    chk("async reset done_a", {31'd0, done_a}, 32'd0);
    chk("async reset stall_a", {31'd0, stall_a}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_op(3'd6, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, "post-reset", 0);

    // start while busy is ignored; a later start is accepted
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, "busy-start", 3);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "after-busy", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
